bsg_gateway_burst_gather: RTL



---
 rtl/bsg_gateway_burst_gather.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bsg_gateway_burst_gather.sv
`default_nettype none
// ============================================================================
// Module   : bsg_gateway_burst_gather
// Function : Round-robin gatherer. It accepts one BedRock-style burst
//            (header + narrow beats) from one of num_chan_p sources at a
//            time. It assembles the beats into a single wide lite message
//            for one downstream port.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_gateway_burst_gather #(
    parameter int num_chan_p       = 2,
    parameter int header_width_p   = 64,
    parameter int in_data_width_p  = 64,
    parameter int out_data_width_p = 512,
    parameter int size_lsb_p       = 0,
    parameter int has_data_bit_p   = 63,
    localparam int c_chan_w        = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_chan_p*header_width_p-1:0]   header_i,
    input  logic [num_chan_p-1:0]                  header_v_i,
    output logic [num_chan_p-1:0]                  header_ready_and_o,
    input  logic [num_chan_p*in_data_width_p-1:0]  data_i,
    input  logic [num_chan_p-1:0]                  data_v_i,
    output logic [num_chan_p-1:0]                  data_ready_and_o,
    output logic [header_width_p-1:0]              mem_header_o,
    output logic [out_data_width_p-1:0]            mem_data_o,
    output logic [c_chan_w-1:0]                    mem_chan_o,
    output logic                                   mem_v_o,
    input  logic                                   mem_ready_and_i
);

    localparam int c_max_beats = out_data_width_p / in_data_width_p;
    localparam int c_beats_w   = $clog2(c_max_beats + 1);

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_data = 2'd1,
        e_send = 2'd2
    } state_e;

    state_e                       r_state;
    logic [c_chan_w-1:0]          r_rr_ptr;
    logic [c_chan_w-1:0]          r_chan;
    logic [c_beats_w-1:0]         r_cnt;
    logic [c_beats_w-1:0]         r_beats;
    logic [header_width_p-1:0]    r_header;
    logic [out_data_width_p-1:0]  r_data;
    logic                         r_mem_v;
    logic [in_data_width_p-1:0]   r_gather      [c_max_beats];
    logic [in_data_width_p-1:0]   w_gather_next [c_max_beats];

    logic                         w_found;
    logic [c_chan_w-1:0]          w_grant;
    logic [header_width_p-1:0]    w_hdr;
    logic [in_data_width_p-1:0]   w_beat;
    logic                         w_data_v;
    logic                         w_hdr_fire;
    logic                         w_data_fire;
    logic                         w_last_beat;
    logic [c_beats_w-1:0]         w_beats;
    logic [c_beats_w-1:0]         w_mask;
    logic [out_data_width_p-1:0]  w_payload;
    int                           w_bits;
    int                           w_nb;

    // Round-robin pick: first requesting channel at or after rr_ptr, wrapping
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            for (int j = 0; j < num_chan_p; j++) begin
                if (!w_found && header_v_i[j] &&
                    ((int'(r_rr_ptr) + i) % num_chan_p == j)) begin
                    w_found = 1'b1;
                    w_grant = c_chan_w'(j);
                end
            end
        end
    end

    // Select the granted header and the active channel's beat; drive readies
    always_comb begin
        w_hdr    = '0;
        w_beat   = '0;
        w_data_v = 1'b0;
        header_ready_and_o = '0;
        data_ready_and_o   = '0;
        for (int j = 0; j < num_chan_p; j++) begin
            if (w_grant == c_chan_w'(j)) begin
                w_hdr = header_i[j*header_width_p +: header_width_p];
            end
            if (r_chan == c_chan_w'(j)) begin
                w_beat   = data_i[j*in_data_width_p +: in_data_width_p];
                w_data_v = data_v_i[j];
            end
            header_ready_and_o[j] = reset_n_i && (r_state == e_idle) &&
                                    w_found && (w_grant == c_chan_w'(j));
            data_ready_and_o[j]   = (r_state == e_data) && (r_chan == c_chan_w'(j));
        end
    end

    assign w_hdr_fire  = reset_n_i && (r_state == e_idle) && w_found;
    assign w_data_fire = (r_state == e_data) && w_data_v;
    assign w_mask      = r_beats - 1'b1;
    assign w_last_beat = (r_cnt == w_mask);

    // Beat count from the header size field, clamped to [1, max beats]
    always_comb begin
        w_bits = 8 << int'(w_hdr[size_lsb_p +: 3]);
        w_nb   = w_bits / in_data_width_p;
        if (w_nb < 1) begin
            w_nb = 1;
        end
        if (w_nb > c_max_beats) begin
            w_nb = c_max_beats;
        end
        w_beats = c_beats_w'(w_nb);
    end

    // Insert the incoming beat and build the replicated payload from it, so
    // the final beat is captured into the output in the same cycle it lands
    always_comb begin
        for (int j = 0; j < c_max_beats; j++) begin
            w_gather_next[j] = r_gather[j];
            if (w_data_fire && (r_cnt == c_beats_w'(j))) begin
                w_gather_next[j] = w_beat;
            end
        end
        w_payload = '0;
        for (int k = 0; k < c_max_beats; k++) begin
            for (int j = 0; j < c_max_beats; j++) begin
                if ((c_beats_w'(k) & w_mask) == c_beats_w'(j)) begin
                    w_payload[k*in_data_width_p +: in_data_width_p] = w_gather_next[j];
                end
            end
        end
    end

    // Transaction FSM with registered message outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= e_idle;
            r_rr_ptr <= '0;
            r_chan   <= '0;
            r_cnt    <= '0;
            r_beats  <= '0;
            r_header <= '0;
            r_data   <= '0;
            r_mem_v  <= 1'b0;
            for (int j = 0; j < c_max_beats; j++) begin
                r_gather[j] <= '0;
            end
        end else begin
            r_gather <= w_gather_next;
            case (r_state)
                e_idle: begin
                    if (w_hdr_fire) begin
                        r_header <= w_hdr;
                        r_chan   <= w_grant;
                        r_beats  <= w_beats;
                        r_cnt    <= '0;
                        if (w_hdr[has_data_bit_p]) begin
                            r_state <= e_data;
                        end else begin
                            r_state <= e_send;
                            r_mem_v <= 1'b1;
                            r_data  <= '0;
                        end
                    end
                end
                e_data: begin
                    if (w_data_fire) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_state <= e_send;
                            r_mem_v <= 1'b1;
                            r_data  <= w_payload;
                        end
                    end
                end
                e_send: begin
                    if (mem_ready_and_i) begin
                        r_state  <= e_idle;
                        r_mem_v  <= 1'b0;
                        r_cnt    <= '0;
                        // The channel just served drops to lowest priority
                        r_rr_ptr <= (r_chan == c_chan_w'(num_chan_p - 1)) ? '0 : r_chan + 1'b1;
                    end
                end
                default: begin
                    r_state <= e_idle;
                end
            endcase
        end
    end

    assign mem_header_o = r_header;
    assign mem_data_o   = r_data;
    assign mem_chan_o   = r_chan;
    assign mem_v_o      = r_mem_v;

endmodule
`default_nettype wire
